// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - ALU operand/control bus between the issue sequencer and the datapath ALU
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
);
  logic [CTRL_BITS-1:0]  ctrl;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] c;
  logic                  zero;
  logic                  over;

  modport master (output ctrl, a, b, input c, zero, over);
  modport slave  (input ctrl, a, b, output c, zero, over);
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I decode-to-ALU issue sequencer with valid/ready result return
module alu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  is_branch,
  output logic                  br_taken,
  output logic                  overflow,
  output logic                  illegal,
  alu_issue_if.master           alu
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CTRL_BITS-1:0] C_AND  = 4'b0000;
  localparam logic [CTRL_BITS-1:0] C_XOR  = 4'b0001;
  localparam logic [CTRL_BITS-1:0] C_ADD  = 4'b0010;
  localparam logic [CTRL_BITS-1:0] C_OR   = 4'b0011;
  localparam logic [CTRL_BITS-1:0] C_SGE  = 4'b0101;
  localparam logic [CTRL_BITS-1:0] C_SUB  = 4'b0110;
  localparam logic [CTRL_BITS-1:0] C_SLT  = 4'b0111;
  localparam logic [CTRL_BITS-1:0] C_SGEU = 4'b1101;
  localparam logic [CTRL_BITS-1:0] C_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {BR_ZERO, BR_NZERO, BR_BIT0} br_mode_t;

  state_t                state, state_next;
  logic                  accept;
  logic [CTRL_BITS-1:0]  dec_ctrl;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_illegal, dec_branch, dec_ovf;
  br_mode_t              dec_mode, mode_q;
  logic                  branch_q, ovf_en_q;

  always_comb begin
    dec_ctrl    = C_ADD;
    dec_b       = rs2_val;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    dec_ovf     = 1'b0;
    dec_mode    = BR_BIT0;
    case (opcode)
      OPC_OP, OPC_IMM: begin
        if (opcode == OPC_IMM) dec_b = imm;
        case (funct3)
          3'b000: begin
            // Immediate form has no SUB; only the register form reports overflow
            dec_ctrl = (opcode == OPC_OP && funct7_5) ? C_SUB : C_ADD;
            dec_ovf  = (opcode == OPC_OP);
          end
          3'b111:  dec_ctrl = C_AND;
          3'b110:  dec_ctrl = C_OR;
          3'b100:  dec_ctrl = C_XOR;
          3'b010:  dec_ctrl = C_SLT;
          3'b011:  dec_ctrl = C_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000:  begin dec_ctrl = C_SUB; dec_mode = BR_ZERO;  end
          3'b001:  begin dec_ctrl = C_SUB; dec_mode = BR_NZERO; end
          3'b100:  dec_ctrl = C_SLT;
          3'b101:  dec_ctrl = C_SGE;
          3'b110:  dec_ctrl = C_SLTU;
          3'b111:  dec_ctrl = C_SGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = dec_illegal ? DONE : EXEC;
      end
      EXEC: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? (dec_illegal ? DONE : EXEC) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu.ctrl  <= '0;
      alu.a     <= '0;
      alu.b     <= '0;
      branch_q  <= 1'b0;
      mode_q    <= BR_BIT0;
      ovf_en_q  <= 1'b0;
      result    <= '0;
      is_branch <= 1'b0;
      br_taken  <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      alu.ctrl  <= dec_ctrl;
      alu.a     <= rs1_val;
      alu.b     <= dec_b;
      branch_q  <= dec_branch;
      mode_q    <= dec_mode;
      ovf_en_q  <= dec_ovf;
      result    <= '0;
      is_branch <= 1'b0;
      br_taken  <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= dec_illegal;
    end else if (state == EXEC) begin
      result    <= alu.c;
      is_branch <= branch_q;
      case (mode_q)
        BR_ZERO:  br_taken <= branch_q & alu.zero;
        BR_NZERO: br_taken <= branch_q & ~alu.zero;
        default:  br_taken <= branch_q & alu.c[0];
      endcase
      overflow  <= alu.over & ovf_en_q;
      illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed scoreboard bench for alu_issue with a behavioural ALU
module tb_alu_issue;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;

  typedef struct packed {
    logic [31:0] result;
    logic        is_branch;
    logic        br_taken;
    logic        overflow;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] result;
  logic        is_branch, br_taken, overflow, illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_issue_if #(.DATA_WIDTH(32), .CTRL_BITS(4)) bus ();

  alu_issue #(.DATA_WIDTH(32), .CTRL_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .is_branch(is_branch), .br_taken(br_taken), .overflow(overflow),
    .illegal(illegal), .alu(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a ^ b;
      4'b0010: return a + b;
      4'b0011: return a | b;
      4'b0101: return 32'($signed(a) >= $signed(b));
      4'b0110: return a - b;
      4'b0111: return 32'($signed(a) < $signed(b));
      4'b1100: return ~(a | b);
      4'b1101: return 32'(a >= b);
      4'b1111: return 32'(a < b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.c    = alu_fn(bus.ctrl, bus.a, bus.b);
  assign bus.zero = (bus.c == 32'd0);
  assign bus.over = (bus.ctrl == 4'b0010) ? (bus.a[31] == bus.b[31]) && (bus.c[31] != bus.a[31]) :
                    (bus.ctrl == 4'b0110) ? (bus.a[31] != bus.b[31]) && (bus.c[31] != bus.a[31]) : 1'b0;

  function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    exp_t e;
    logic [31:0] b;
    e = '0;
    if (op == OP || op == IMM) begin
      b = (op == OP) ? r2 : im;
      case (f3)
        3'b000: if (op == OP && f75) begin
          e.result   = r1 - b;
          e.overflow = (r1[31] != b[31]) && (e.result[31] != r1[31]);
        end else begin
          e.result   = r1 + b;
          e.overflow = (op == OP) && (r1[31] == b[31]) && (e.result[31] != r1[31]);
        end
        3'b111:  e.result = r1 & b;
        3'b110:  e.result = r1 | b;
        3'b100:  e.result = r1 ^ b;
        3'b010:  e.result = 32'($signed(r1) < $signed(b));
        3'b011:  e.result = 32'(r1 < b);
        default: e.illegal = 1'b1;
      endcase
    end else if (op == BR) begin
      e.is_branch = 1'b1;
      case (f3)
        3'b000: begin e.result = r1 - r2; e.br_taken = (r1 == r2); end
        3'b001: begin e.result = r1 - r2; e.br_taken = (r1 != r2); end
        3'b100: begin e.br_taken = ($signed(r1) < $signed(r2));  e.result = 32'(e.br_taken); end
        3'b101: begin e.br_taken = ($signed(r1) >= $signed(r2)); e.result = 32'(e.br_taken); end
        3'b110: begin e.br_taken = (r1 < r2);  e.result = 32'(e.br_taken); end
        3'b111: begin e.br_taken = (r1 >= r2); e.result = 32'(e.br_taken); end
        default: begin e = '0; e.illegal = 1'b1; end
      endcase
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, result, e.result);
    check({tag, " flags"}, {28'd0, is_branch, br_taken, overflow, illegal},
          {28'd0, e.is_branch, e.br_taken, e.overflow, e.illegal});
  endtask

  task automatic collect(input string tag);
    compare_front(tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7_5 = f75; rs1_val = r1; rs2_val = r2; imm = im;
    in_valid = 1'b1;
  endtask

  // Presents one op from IDLE, checks its accept-to-out_valid latency, and leaves it pending.
  task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input int exp_lat, input logic [3:0] exp_ctrl);
    int lat;
    @(negedge clk);
    drive(op, f3, f75, r1, r2, im);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(ref_model(op, f3, f75, r1, r2, im));
    if (exp_lat == 2) begin
      check({tag, " alu_ctrl"}, 32'(bus.ctrl), 32'(exp_ctrl));
      check({tag, " alu_a"}, bus.a, r1);
    end
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                     input int exp_lat, input logic [3:0] exp_ctrl);
    issue(tag, op, f3, f75, r1, r2, im, exp_lat, exp_ctrl);
    collect(tag);
  endtask

  initial begin
    #3;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {28'd0, is_branch, br_taken, overflow, illegal}, 32'd0);
    check("rst alu_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst alu_ab", bus.a | bus.b, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);

    run("add",      OP,  3'b000, 1'b0, 32'd75, 32'd25, 32'd0, 2, 4'b0010);
    run("sub_ovf",  OP,  3'b000, 1'b1, 32'h8000_0001, 32'h10, 32'd0, 2, 4'b0110);
    run("beq",      BR,  3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 2, 4'b0110);
    run("bne",      BR,  3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 2, 4'b0110);
    run("bltu",     BR,  3'b110, 1'b0, 32'h0FFF_BEEF, 32'hFFFF_FFF3, 32'd0, 2, 4'b1111);
    run("imm_add",  IMM, 3'b000, 1'b1, 32'd7, 32'd99, 32'd3, 2, 4'b0010);
    run("op_ill",   OP,  3'b001, 1'b0, 32'd1, 32'd2, 32'd0, 1, 4'b0000);
    run("bne_ovf",  BR,  3'b001, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 2, 4'b0110);
    run("imm_ovf",  IMM, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd1, 2, 4'b0010);
    run("blt",      BR,  3'b100, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 2, 4'b0111);
    run("bge",      BR,  3'b101, 1'b0, 32'd3, 32'hFFFF_FFFE, 32'd0, 2, 4'b0101);
    run("bgeu",     BR,  3'b111, 1'b0, 32'd3, 32'hFFFF_FFFE, 32'd0, 2, 4'b1101);
    run("and",      OP,  3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 2, 4'b0000);
    run("ori",      IMM, 3'b110, 1'b0, 32'hF000_0000, 32'd0, 32'h0000_00A5, 2, 4'b0011);
    run("slt",      OP,  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, 4'b0111);
    run("sltiu",    IMM, 3'b011, 1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 2, 4'b1111);
    run("imm_ill",  IMM, 3'b101, 1'b0, 32'd1, 32'd2, 32'd3, 1, 4'b0000);
    run("br_ill",   BR,  3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 1, 4'b0000);
    run("opc_ill",  7'b0000011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 1, 4'b0000);

    // Back-pressure: result must sit still while out_ready is low
    issue("bp_xor", OP, 3'b100, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_00FF, 32'd0, 2, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp result", result, 32'hA5A5_0F0F ^ 32'h0FF0_00FF);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive(OP, 3'b000, 1'b0, 32'd1000, 32'd234, 32'd0);
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    compare_front("bp_xor");
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.push_back(ref_model(OP, 3'b000, 1'b0, 32'd1000, 32'd234, 32'd0));
    check("b2b exec out_valid", 32'(out_valid), 32'd0);
    check("b2b alu_a", bus.a, 32'd1000);
    @(posedge clk); #1;
    collect("b2b_add");

    // Reset while the op is in EXEC discards it
    @(negedge clk);
    drive(OP, 3'b000, 1'b1, 32'd50, 32'd8, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_exec pre ctrl", 32'(bus.ctrl), 32'b0110);
    rst = 1'b1;
    #1;
    check("rst_exec alu_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_exec out_valid", 32'(out_valid), 32'd0);
    check("rst_exec result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_exec in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_exec no out_valid", 32'(out_valid), 32'd0);
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
